// File: rtl/rv_hazard_unit_pkg.sv
// Shared types and select codes for the pipeline hazard unit.
package rv_hazard_unit_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;
  localparam fwd_sel_t FWD_WB   = 2'b10;
  localparam fwd_sel_t FWD_MEM  = 2'b11;

  // MEM beats WB; x0 is hardwired and never forwarded.
  function automatic fwd_sel_t fwd_pick(logic rs_nonzero, logic mem_hit, logic wb_hit);
    if (!rs_nonzero)  return FWD_NONE;
    else if (mem_hit) return FWD_MEM;
    else if (wb_hit)  return FWD_WB;
    else              return FWD_NONE;
  endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// Pending-write scoreboard for the multi-cycle MDU, with bypassed read ports.
module rv_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [REG_AW-1:0]        set_rd,
  input  logic                     clr_en,
  input  logic [REG_AW-1:0]        clr_rd,
  input  logic [NUM_RD*REG_AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     any_busy,
  output logic [2**REG_AW-1:0]     busy
);

  logic [2**REG_AW-1:0] busy_q, busy_d, set_mask, busy_eff;

  always_comb begin
    set_mask = '0;
    if (set_en && (set_rd != '0)) set_mask[set_rd] = 1'b1;
    busy_d = busy_q;
    if (clr_en) busy_d[clr_rd] = 1'b0;
    // Set applied after clear so a same-register issue wins over writeback.
    busy_d = busy_d | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // The issuing register already counts as busy in its issue cycle.
  assign busy_eff = busy_q | set_mask;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_busy[i] = busy_eff[rd_addr[i*REG_AW +: REG_AW]];
  end

  assign any_busy = |busy_eff;
  assign busy     = busy_q;

endmodule

// File: rtl/rv_hazard_unit.sv
// EX operand forwarding, load-use / MDU stall detection and branch flush sequencing.
module rv_hazard_unit
  import rv_hazard_unit_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_reg_write,
  input  logic                      mem_mem_read,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_reg_write,
  input  logic                      id_is_mdu,
  input  logic                      mdu_issue,
  input  logic [REG_AW-1:0]         mdu_issue_rd,
  input  logic                      mdu_wb,
  input  logic [REG_AW-1:0]         mdu_wb_rd,
  input  logic                      branch_taken,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic                      flush_id,
  output logic [2**REG_AW-1:0]      sb_busy,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [NUM_SRC-1:0] lu_src, sb_src, sb_rd_busy;
  logic               sb_any;
  logic               load_use, sb_hit, flushing, stall;
  logic [1:0]         fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  rv_scoreboard #(
    .REG_AW (REG_AW),
    .NUM_RD (NUM_SRC)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (mdu_issue),
    .set_rd   (mdu_issue_rd),
    .clr_en   (mdu_wb),
    .clr_rd   (mdu_wb_rd),
    .rd_addr  (id_rs),
    .rd_busy  (sb_rd_busy),
    .any_busy (sb_any),
    .busy     (sb_busy)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] ex_r, id_r;
    assign ex_r = ex_rs[i*REG_AW +: REG_AW];
    assign id_r = id_rs[i*REG_AW +: REG_AW];

    // A load in MEM has no data yet, so it is not a forwarding source.
    assign fwd_sel[i*2 +: 2] = fwd_pick(ex_r != '0,
                                        (ex_r == mem_rd) && mem_reg_write && !mem_mem_read,
                                        (ex_r == wb_rd) && wb_reg_write);

    assign lu_src[i] = id_rs_used[i] && (id_r != '0) && ex_mem_read && ex_reg_write &&
                       (id_r == ex_rd);
    assign sb_src[i] = id_rs_used[i] && sb_rd_busy[i];
  end

  assign load_use = |lu_src;
  // Only one MDU op may be in flight, so a new MDU op waits for any pending write.
  assign sb_hit   = (|sb_src) || (id_is_mdu && sb_any);

  assign flushing  = branch_taken || (fcnt_q != '0);
  assign stall     = rst_n && (load_use || sb_hit) && !flushing;
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = stall || (rst_n && branch_taken);
  assign flush_id  = rst_n && flushing;

  always_comb begin
    fcnt_d = fcnt_q;
    if (branch_taken)        fcnt_d = 2'(FLUSH_CYC - 1);
    else if (fcnt_q != '0)   fcnt_d = fcnt_q - 2'd1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Randomized and directed bench for rv_hazard_unit against a behavioural model.
module tb_rv_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] id_rs, ex_rs;
  logic [1:0] id_rs_used;
  logic [4:0] ex_rd, mem_rd, wb_rd, mdu_issue_rd, mdu_wb_rd;
  logic ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write;
  logic id_is_mdu, mdu_issue, mdu_wb, branch_taken;

  logic [3:0]  fwd_sel_a, fwd_sel_b;
  logic        stall_if_a, stall_id_a, bubble_ex_a, flush_id_a;
  logic        stall_if_b, stall_id_b, bubble_ex_b, flush_id_b;
  logic [31:0] sb_busy_a, sb_busy_b;
  logic [31:0] stall_cnt_a;
  logic [3:0]  stall_cnt_b;

  rv_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .FLUSH_CYC(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .id_is_mdu(id_is_mdu),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd), .mdu_wb(mdu_wb),
    .mdu_wb_rd(mdu_wb_rd), .branch_taken(branch_taken), .fwd_sel(fwd_sel_a),
    .stall_if(stall_if_a), .stall_id(stall_id_a), .bubble_ex(bubble_ex_a),
    .flush_id(flush_id_a), .sb_busy(sb_busy_a), .stall_cnt(stall_cnt_a)
  );

  rv_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .FLUSH_CYC(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .id_is_mdu(id_is_mdu),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd), .mdu_wb(mdu_wb),
    .mdu_wb_rd(mdu_wb_rd), .branch_taken(branch_taken), .fwd_sel(fwd_sel_b),
    .stall_if(stall_if_b), .stall_id(stall_id_b), .bubble_ex(bubble_ex_b),
    .flush_id(flush_id_b), .sb_busy(sb_busy_b), .stall_cnt(stall_cnt_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: set of registers with an MDU write pending,
  // remaining flush cycles and stall counts for both configurations.
  bit     pend[32];
  int     flush_left_a, flush_left_b;
  longint cnt_a, cnt_b;

  function automatic logic [1:0] m_fwd(int i);
    logic [4:0] r;
    r = ex_rs[i*5 +: 5];
    if (r == 0) return 2'b00;
    if (r == mem_rd && mem_reg_write && !mem_mem_read) return 2'b11;
    if (r == wb_rd && wb_reg_write) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_pending(int r);
    return pend[r] || (mdu_issue && mdu_issue_rd == 5'(r) && r != 0);
  endfunction

  function automatic bit m_hazard();
    bit h;
    logic [4:0] r;
    h = 0;
    for (int i = 0; i < 2; i++) begin
      r = id_rs[i*5 +: 5];
      if (id_rs_used[i] && r != 0 && ex_mem_read && ex_reg_write && r == ex_rd) h = 1;
      if (id_rs_used[i] && m_pending(int'(r))) h = 1;
    end
    if (id_is_mdu) for (int r2 = 0; r2 < 32; r2++) if (m_pending(r2)) h = 1;
    return h;
  endfunction

  // {stall_if, stall_id, bubble_ex, flush_id}
  function automatic logic [3:0] m_ctrl(int flush_left);
    bit fl, st;
    fl = branch_taken || flush_left > 0;
    st = rst_n && m_hazard() && !fl;
    return {st, st, st || (rst_n && branch_taken), rst_n && fl};
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = pend[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    flush_left_a = 0; flush_left_b = 0; cnt_a = 0; cnt_b = 0;
  endtask

  task automatic model_clock();
    logic [3:0] ca, cb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ca = m_ctrl(flush_left_a);
    cb = m_ctrl(flush_left_b);
    if (ca[3] && cnt_a < 64'hFFFF_FFFF) cnt_a++;
    if (cb[3] && cnt_b < 15) cnt_b++;
    if (branch_taken) begin
      flush_left_a = 0; flush_left_b = 1;
    end else begin
      if (flush_left_a > 0) flush_left_a--;
      if (flush_left_b > 0) flush_left_b--;
    end
    if (mdu_wb) pend[mdu_wb_rd] = 0;
    if (mdu_issue && mdu_issue_rd != 0) pend[mdu_issue_rd] = 1;
  endtask

  task automatic cycle();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; ex_rs = '0; id_rs_used = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    mdu_issue_rd = '0; mdu_wb_rd = '0; ex_reg_write = 0; ex_mem_read = 0;
    mem_reg_write = 0; mem_mem_read = 0; wb_reg_write = 0; id_is_mdu = 0;
    mdu_issue = 0; mdu_wb = 0; branch_taken = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd7; id_rs[5 +: 5] = 5'd7; id_rs_used = 2'b10;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst_n = 0;
    ex_rs[4:0] = 5'd5; mem_rd = 5'd5; mem_reg_write = 1;
    set_load_use();
    branch_taken = 1;
    #1;
    n_cmp++;
    if (fwd_sel_a[1:0] !== 2'b11) begin
      n_err++; $display("FAIL reset_fwd: got %b want 11", fwd_sel_a[1:0]);
    end
    n_cmp++;
    if ({stall_if_a, stall_id_a, bubble_ex_a, flush_id_a} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000",
                        {stall_if_a, stall_id_a, bubble_ex_a, flush_id_a});
    end
    n_cmp++;
    if (sb_busy_a !== 32'h0 || stall_cnt_a !== 32'h0) begin
      n_err++; $display("FAIL reset_state: got sb %h cnt %0d want 0 0", sb_busy_a, stall_cnt_a);
    end
    model_reset();
    cycle();
    cycle();
    clear_inputs();
    rst_n = 1;
    #1;
    n_cmp++;
    if (stall_cnt_a !== 32'h0 || sb_busy_b !== 32'h0) begin
      n_err++; $display("FAIL reset_held: got cnt %0d sb %h want 0 0", stall_cnt_a, sb_busy_b);
    end
    cycle();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    ex_rs[4:0] = 5'd5; mem_rd = 5'd5; mem_reg_write = 1; wb_rd = 5'd5; wb_reg_write = 1;
    #1;
    n_cmp++;
    if (fwd_sel_a[1:0] !== 2'b11) begin
      n_err++; $display("FAIL fwd_mem: got %b want 11", fwd_sel_a[1:0]);
    end
    mem_reg_write = 0;
    #1;
    n_cmp++;
    if (fwd_sel_a[1:0] !== 2'b10) begin
      n_err++; $display("FAIL fwd_wb: got %b want 10", fwd_sel_a[1:0]);
    end
    mem_reg_write = 1; mem_mem_read = 1;
    #1;
    n_cmp++;
    if (fwd_sel_a[1:0] !== 2'b10) begin
      n_err++; $display("FAIL fwd_mem_load: got %b want 10", fwd_sel_a[1:0]);
    end
    ex_rs[4:0] = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    #1;
    n_cmp++;
    if (fwd_sel_a[1:0] !== 2'b00) begin
      n_err++; $display("FAIL fwd_zero: got %b want 00", fwd_sel_a[1:0]);
    end
    for (int k = 0; k < 60; k++) begin
      ex_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom); mem_mem_read = 1'($urandom);
      wb_reg_write = 1'($urandom);
      #1;
      n_cmp++;
      if (fwd_sel_a !== {m_fwd(1), m_fwd(0)} || fwd_sel_b !== {m_fwd(1), m_fwd(0)}) begin
        n_err++; $display("FAIL fwd_rand: got %b/%b want %b", fwd_sel_a, fwd_sel_b,
                          {m_fwd(1), m_fwd(0)});
      end
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    longint c0;
    clear_inputs();
    c0 = cnt_a;
    set_load_use();
    #1;
    n_cmp++;
    if ({stall_if_a, stall_id_a, bubble_ex_a, flush_id_a} !== 4'b1110) begin
      n_err++; $display("FAIL lu_stall: got %b want 1110",
                        {stall_if_a, stall_id_a, bubble_ex_a, flush_id_a});
    end
    cycle();
    ex_mem_read = 0; ex_reg_write = 0;
    #1;
    n_cmp++;
    if ({stall_if_a, stall_id_a, bubble_ex_a} !== 3'b000 || stall_cnt_a !== 32'(c0 + 1)) begin
      n_err++; $display("FAIL lu_release: got %b cnt %0d want 000 cnt %0d",
                        {stall_if_a, stall_id_a, bubble_ex_a}, stall_cnt_a, c0 + 1);
    end
    set_load_use();
    id_rs_used = 2'b00;
    #1;
    n_cmp++;
    if (stall_if_a !== 1'b0) begin
      n_err++; $display("FAIL lu_unused: got %b want 0", stall_if_a);
    end
    id_rs_used = 2'b11; ex_rd = 5'd0; id_rs = '0;
    #1;
    n_cmp++;
    if (stall_if_a !== 1'b0) begin
      n_err++; $display("FAIL lu_x0: got %b want 0", stall_if_a);
    end
    cycle();
    clear_inputs();
  endtask

  task automatic test_mdu();
    longint c0;
    clear_inputs();
    c0 = cnt_a;
    mdu_issue = 1; mdu_issue_rd = 5'd9; id_rs[4:0] = 5'd9; id_rs_used = 2'b01;
    #1;
    n_cmp++;
    if (stall_if_a !== 1'b1) begin
      n_err++; $display("FAIL mdu_issue_cycle: got %b want 1", stall_if_a);
    end
    cycle();
    mdu_issue = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (stall_if_a !== 1'b1 || sb_busy_a[9] !== 1'b1) begin
        n_err++; $display("FAIL mdu_pending: got stall %b busy %b want 1 1",
                          stall_if_a, sb_busy_a[9]);
      end
      cycle();
    end
    mdu_wb = 1; mdu_wb_rd = 5'd9;
    #1;
    n_cmp++;
    if (stall_if_a !== 1'b1) begin
      n_err++; $display("FAIL mdu_wb_cycle: got %b want 1", stall_if_a);
    end
    cycle();
    mdu_wb = 0;
    #1;
    n_cmp++;
    if (stall_if_a !== 1'b0 || sb_busy_a[9] !== 1'b0 || stall_cnt_a !== 32'(c0 + 5)) begin
      n_err++; $display("FAIL mdu_done: got stall %b busy %b cnt %0d want 0 0 %0d",
                        stall_if_a, sb_busy_a[9], stall_cnt_a, c0 + 5);
    end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    clear_inputs();
    mdu_issue = 1; mdu_issue_rd = 5'd9;
    cycle();
    mdu_wb = 1; mdu_wb_rd = 5'd9;
    cycle();
    mdu_issue = 0; mdu_wb = 0;
    #1;
    n_cmp++;
    if (sb_busy_a[9] !== 1'b1) begin
      n_err++; $display("FAIL sim_set_wins: got %b want 1", sb_busy_a[9]);
    end
    id_is_mdu = 1;
    #1;
    n_cmp++;
    if (stall_if_a !== 1'b1) begin
      n_err++; $display("FAIL mdu_in_flight: got %b want 1", stall_if_a);
    end
    id_is_mdu = 0; mdu_wb = 1;
    cycle();
    mdu_wb = 0; mdu_issue = 1; mdu_issue_rd = 5'd0;
    cycle();
    mdu_issue = 0;
    #1;
    n_cmp++;
    if (sb_busy_a !== 32'h0) begin
      n_err++; $display("FAIL sim_x0: got %h want 0", sb_busy_a);
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    set_load_use();
    branch_taken = 1;
    #1;
    n_cmp++;
    if ({flush_id_a, bubble_ex_a, stall_if_a, flush_id_b, bubble_ex_b, stall_if_b} !== 6'b110110)
    begin
      n_err++; $display("FAIL br_lu: got %b want 110110",
                        {flush_id_a, bubble_ex_a, stall_if_a, flush_id_b, bubble_ex_b, stall_if_b});
    end
    cycle();
    branch_taken = 0;
    #1;
    n_cmp++;
    if ({flush_id_a, stall_if_a, flush_id_b, bubble_ex_b, stall_if_b} !== 5'b01100) begin
      n_err++; $display("FAIL br_second: got %b want 01100",
                        {flush_id_a, stall_if_a, flush_id_b, bubble_ex_b, stall_if_b});
    end
    cycle();
    #1;
    n_cmp++;
    if ({flush_id_b, stall_if_b} !== 2'b01) begin
      n_err++; $display("FAIL br_third: got %b want 01", {flush_id_b, stall_if_b});
    end
    cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [3:0] ea, eb;
    for (int k = 0; k < 400; k++) begin
      id_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used = 2'($urandom); ex_rd = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      mem_reg_write = 1'($urandom); mem_mem_read = 1'($urandom);
      wb_reg_write = 1'($urandom); id_is_mdu = ($urandom_range(0, 7) == 0);
      mdu_issue = ($urandom_range(0, 5) == 0); mdu_issue_rd = 5'($urandom_range(0, 3));
      mdu_wb = ($urandom_range(0, 3) == 0); mdu_wb_rd = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      #1;
      ea = m_ctrl(flush_left_a);
      eb = m_ctrl(flush_left_b);
      n_cmp++;
      if ({stall_if_a, stall_id_a, bubble_ex_a, flush_id_a} !== ea ||
          {stall_if_b, stall_id_b, bubble_ex_b, flush_id_b} !== eb) begin
        n_err++; $display("FAIL rand_ctrl: got %b/%b want %b/%b",
                          {stall_if_a, stall_id_a, bubble_ex_a, flush_id_a},
                          {stall_if_b, stall_id_b, bubble_ex_b, flush_id_b}, ea, eb);
      end
      n_cmp++;
      if (fwd_sel_a !== {m_fwd(1), m_fwd(0)}) begin
        n_err++; $display("FAIL rand_fwd: got %b want %b", fwd_sel_a, {m_fwd(1), m_fwd(0)});
      end
      n_cmp++;
      if (sb_busy_a !== m_busy_vec() || stall_cnt_a !== 32'(cnt_a) ||
          stall_cnt_b !== 4'(cnt_b)) begin
        n_err++; $display("FAIL rand_state: got sb %h cnt %0d/%0d want %h %0d/%0d",
                          sb_busy_a, stall_cnt_a, stall_cnt_b, m_busy_vec(), cnt_a, cnt_b);
      end
      cycle();
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    #1 rst_n = 0;
    model_reset();
    #1 rst_n = 1;
    cycle();
    mdu_issue = 1; mdu_issue_rd = 5'd9;
    cycle();
    mdu_issue = 0;
    set_load_use();
    for (int k = 0; k < 40; k++) cycle();
    n_cmp++;
    if (stall_cnt_a !== 32'd40 || stall_cnt_b !== 4'd15 || sb_busy_a[9] !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: got cnt %0d/%0d busy %b want 40/15 1",
                        stall_cnt_a, stall_cnt_b, sb_busy_a[9]);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (stall_cnt_a !== 32'd0 || stall_cnt_b !== 4'd0 || sb_busy_a !== 32'h0 ||
        stall_if_a !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got cnt %0d/%0d sb %h stall %b want 0",
                        stall_cnt_a, stall_cnt_b, sb_busy_a, stall_if_a);
    end
    clear_inputs();
    cycle();
    rst_n = 1;
    mdu_wb = 1; mdu_wb_rd = 5'd9;
    cycle();
    mdu_wb = 0;
    #1;
    n_cmp++;
    if (sb_busy_a !== 32'h0) begin
      n_err++; $display("FAIL stale_wb: got %h want 0", sb_busy_a);
    end
  endtask

  initial begin
    model_reset();
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mdu();
    test_simultaneous();
    test_branch();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end want end");
    $fatal(1);
  end

endmodule
